// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU data port (0) and host loader (1) share one synchronous RAM.
// Latency: request sampled at edge E, grant and write in cycle E+1, read data valid in cycle E+3.
// Backpressure: requests are sampled only in IDLE; a requester keeps req high until it sees its gnt pulse.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   reqN/weN/addrN/wdataN     request, write flag, word address and write data from requester N
//   gntN                      one-cycle grant pulse to requester N
//   rvalidN/rdataN            one-cycle read-valid pulse and registered read data for requester N
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   synchronous memory port (read data one cycle after mem_en)
//   busy                      high while a transaction is in flight
//   conflicts                 saturating count of cycles where both requesters competed
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [7:0]    conflicts
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state;
  logic   winner;     // index of the requester owning the current transaction
  logic   last_gnt;   // round-robin pointer: requester granted most recently
  logic   tie;
  logic   pick;

  assign tie  = req0 & req1;
  // On a tie the requester not granted last wins; otherwise the lone requester wins.
  assign pick = tie ? ~last_gnt : req1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      winner    <= 1'b0;
      last_gnt  <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      conflicts <= '0;
    end else begin
      // Pulse outputs default low; only the cycle that needs them raises them.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state     <= GRANT;
            winner    <= pick;
            last_gnt  <= pick;
            gnt0      <= ~pick;
            gnt1      <= pick;
            mem_en    <= 1'b1;
            mem_we    <= pick ? we1 : we0;
            mem_addr  <= pick ? addr1 : addr0;
            mem_wdata <= pick ? wdata1 : wdata0;
            if (tie && (conflicts != 8'hFF)) begin
              conflicts <= conflicts + 8'd1;
            end
          end
        end

        GRANT: begin
          // mem_we still holds this transaction's direction during GRANT.
          state <= mem_we ? IDLE : RDWAIT;
        end

        RDWAIT: begin
          state <= IDLE;
          if (winner) begin
            rdata1  <= mem_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_rdata;
            rvalid0 <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic [7:0]  conflicts;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the arbiter.
  logic [31:0] m [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) m[mem_addr] <= mem_wdata;
      else        mem_rdata   <= m[mem_addr];
    end
  end

  // ---------------- Transaction-level reference model ----------------
  // Tracks time in edges since reset: a sampled request occupies the arbiter
  // for 2 edges (write) or 3 edges (read); read data arrives 2 edges after sampling.
  int          t = 0, free_at = 0, rd_at = -1;
  logic        rd_w = 1'b0, last = 1'b1, w;
  logic [31:0] rd_val = '0;
  logic        e_gnt0 = 0, e_gnt1 = 0, e_rv0 = 0, e_rv1 = 0, e_en = 0, e_we = 0, e_busy = 0;
  logic [7:0]  e_addr = '0, e_conf = '0;
  logic [31:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = 0; free_at = 0; rd_at = -1; last = 1'b1;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_en = 0; e_we = 0; e_busy = 0;
      e_addr = '0; e_conf = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_en = 0; e_we = 0;
      if (t == rd_at) begin
        if (rd_w) begin e_rv1 = 1; e_rd1 = rd_val; end
        else      begin e_rv0 = 1; e_rd0 = rd_val; end
      end
      if (t >= free_at && (req0 || req1)) begin
        if (req0 && req1) begin
          w = (last == 1'b1) ? 1'b0 : 1'b1;
          if (e_conf < 8'd255) e_conf = e_conf + 8'd1;
        end else begin
          w = req1;
        end
        last    = w;
        e_gnt0  = (w == 1'b0);
        e_gnt1  = (w == 1'b1);
        e_en    = 1;
        e_we    = w ? we1 : we0;
        e_addr  = w ? addr1 : addr0;
        e_wdata = w ? wdata1 : wdata0;
        if (e_we) begin
          free_at = t + 2;
        end else begin
          free_at = t + 3;
          rd_at   = t + 2;
          rd_w    = w;
          rd_val  = m[e_addr];
        end
      end
      e_busy = (t + 1 < free_at);
      t = t + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy} !== {e_gnt0, e_gnt1, e_rv0, e_rv1, e_en, e_we, e_busy} ||
        conflicts !== e_conf || mem_addr !== e_addr || mem_wdata !== e_wdata ||
        rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
      errors++;
      $display("FAIL model_cmp @%0t act g=%b%b rv=%b%b en=%b we=%b busy=%b conf=%0d a=%h wd=%h rd0=%h rd1=%h exp g=%b%b rv=%b%b en=%b we=%b busy=%b conf=%0d a=%h wd=%h rd0=%h rd1=%h",
               $time, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy, conflicts, mem_addr, mem_wdata, rdata0, rdata1,
               e_gnt0, e_gnt1, e_rv0, e_rv1, e_en, e_we, e_busy, e_conf, e_addr, e_wdata, e_rd0, e_rd1);
    end
  end

  // ---------------- Directed stimulus with literal expectations ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    for (int i = 0; i < 256; i++) m[i] = 32'h0;
    m[8'h20] = 32'h12345678;
    m[8'h30] = 32'hA5A5A5A5;

    // Reset state
    tick(); tick();
    chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_busy_conf", {23'd0, busy, conflicts}, 32'd0);
    rst = 1'b1;

    // req0 write: grant in the very next cycle with the memory port driven
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
    tick();
    chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
    chk("wr_gnt1", {31'd0, gnt1}, 32'd0);
    chk("wr_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("wr_addr", {24'd0, mem_addr}, 32'h10);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    req0 = 0; we0 = 0;
    tick();
    chk("wr_done", {29'd0, gnt0, mem_en, busy}, 32'd0);
    chk("wr_addr_hold", {24'd0, mem_addr}, 32'h10);

    // req0 read of 0x30 to give rdata0 a known value
    req0 = 1; addr0 = 8'h30;
    tick(); req0 = 0;
    tick(); tick();
    chk("rd0_rvalid", {31'd0, rvalid0}, 32'd1);
    chk("rd0_data", rdata0, 32'hA5A5A5A5);

    // req1 read of 0x20: rvalid1 three cycles after sampling, rdata0 untouched
    req1 = 1; we1 = 0; addr1 = 8'h20;
    tick();
    chk("rd1_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 0;
    tick();
    chk("rd1_wait", {30'd0, rvalid1, busy}, 32'd1);
    tick();
    chk("rd1_rvalid", {31'd0, rvalid1}, 32'd1);
    chk("rd1_data", rdata1, 32'h12345678);
    chk("rd1_rdata0_kept", rdata0, 32'hA5A5A5A5);
    tick();
    chk("rd1_rvalid_pulse", {31'd0, rvalid1}, 32'd0);
    chk("rd1_data_hold", rdata1, 32'h12345678);

    // Both requesters held high: round-robin order 0,1,0,1
    req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 32'h11110000;
    req1 = 1; we1 = 1; addr1 = 8'h41; wdata1 = 32'h22220000;
    for (int i = 0; i < 20 && order.size() < 4; i++) begin
      tick();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk("rr_count", order.size(), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);
    tick();
    chk("rr_conflicts", {24'd0, conflicts}, 32'd4);

    // 300 tie cycles: counter saturates at 255
    req0 = 1; req1 = 1;
    for (int i = 0; i < 600; i++) tick();
    req0 = 0; req1 = 0;
    tick();
    chk("sat_conflicts", {24'd0, conflicts}, 32'd255);

    // Reset asserted while a read sits in RDWAIT
    req1 = 1; we1 = 0; addr1 = 8'h20;
    tick(); req1 = 0;
    tick();
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 0;
    #1;
    chk("arst_ctl", {25'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}, 32'd0);
    chk("arst_conf", {24'd0, conflicts}, 32'd0);
    chk("arst_rdata", rdata0 | rdata1, 32'd0);
    chk("arst_mem", {24'd0, mem_addr} | mem_wdata, 32'd0);
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
    end
    req0 = 1; we0 = 1; req1 = 1; we1 = 1;
    tick();
    chk("post_rst_tie_winner", {30'd0, gnt0, gnt1}, 32'd2);
    chk("post_rst_conf", {24'd0, conflicts}, 32'd1);
    req0 = 0; req1 = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 8, address width; DW, default 32, data width.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single system clock; all logic uses its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-004 Ports req0/req1 SHALL be inputs, 1 bit wide, carrying the access request from requester 0 (CPU data port) and requester 1 (host loader).
REQ-005 Ports we0/we1 SHALL be inputs, 1 bit wide: 1 = write, 0 = read.
REQ-006 Ports addr0/addr1 SHALL be inputs, AW bits wide, carrying the word address.
REQ-007 Ports wdata0/wdata1 SHALL be inputs, DW bits wide, carrying write data.
REQ-008 Ports gnt0/gnt1 SHALL be outputs, 1 bit wide, each a one-cycle grant pulse.
REQ-009 Ports rvalid0/rvalid1 SHALL be outputs, 1 bit wide, each a one-cycle read-data-valid pulse.
REQ-010 Ports rdata0/rdata1 SHALL be outputs, DW bits wide, carrying registered read data.
REQ-011 Port mem_en SHALL be an output, 1 bit wide, and is the memory access enable.
REQ-012 Port mem_we SHALL be an output, 1 bit wide, and is the memory write enable.
REQ-013 Port mem_addr SHALL be an output, AW bits wide, and is the memory address.
REQ-014 Port mem_wdata SHALL be an output, DW bits wide, and is the memory write data.
REQ-015 Port mem_rdata SHALL be an input, DW bits wide; it is synchronous memory read data, valid one cycle after mem_en with mem_we=0.
REQ-016 Port busy SHALL be an output, 1 bit wide, and is high whenever the state is not IDLE.
REQ-017 Port conflicts SHALL be an output, 8 bits wide, and is a saturating count of contested arbitration cycles.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, GRANT, RDWAIT.
REQ-019 req0/req1 SHALL be sampled only at edges ending an IDLE cycle; requests in other states are ignored until the return to IDLE.
REQ-020 IDLE with no request SHALL remain in IDLE.
REQ-021 IDLE with one or more requests SHALL go to GRANT, capturing the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata and its index into a winner register.
REQ-022 When exactly one requester is active, that requester SHALL win.
REQ-023 When both requesters are active, the requester not granted last SHALL win (round-robin pointer); the pointer resets to 1, so req0 wins the first tie.
REQ-024 Each tie cycle SHALL increment conflicts, which saturates at 255 and does not wrap.
REQ-025 In the GRANT cycle, gnt of the winner SHALL be 1 and mem_en SHALL be 1; all other cycles have gnt0=gnt1=0, mem_en=0 and mem_we=0.
REQ-026 GRANT SHALL go to IDLE if the access is a write and to RDWAIT if it is a read.
REQ-027 In RDWAIT, mem_rdata SHALL be captured into the winner's rdata, and the state goes to IDLE.
REQ-028 The winner's rvalid SHALL pulse in the cycle following RDWAIT, concurrent with IDLE.
REQ-029 rdataN SHALL hold its value until the next read by the same requester; the other requester's rdata is unchanged.
REQ-030 Latency SHALL be: request sampled at edge E, gnt in cycle E+1, write committed in cycle E+1, rvalid in cycle E+3.
REQ-031 Throughput SHALL be 1 write per 2 cycles and 1 read per 3 cycles.
REQ-032 A requester SHALL deassert req at the edge ending its gnt cycle; a req still high when IDLE is re-entered is a new request.
REQ-033 mem_addr and mem_wdata SHALL hold their last values outside GRANT.
REQ-034 The round-robin pointer SHALL update to the winner on each grant.

Reset
REQ-035 rst low SHALL immediately, asynchronously, force: state=IDLE, gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, conflicts=0, pointer=1.
REQ-036 An in-flight transaction interrupted by reset SHALL be dropped, with no gnt or rvalid issued after release.
REQ-037 The first arbitration SHALL occur at the first rising edge with rst high.

Verification
REQ-038 The bench SHALL cover: req0 write, addr0=8'h10, wdata0=32'hDEADBEEF -> gnt0 one cycle later, with mem_en=1, mem_we=1, mem_addr=8'h10, mem_wdata=DEADBEEF in that same cycle.
REQ-039 The bench SHALL cover: req1 read of addr1=8'h20 with memory returning 32'h12345678 -> rvalid1 3 cycles after sampling, rdata1=12345678, rdata0 unchanged.
REQ-040 The bench SHALL cover: req0 and req1 held high for 4 grants -> order 0,1,0,1, with conflicts counting each tie cycle.
REQ-041 The bench SHALL cover: 300 tie cycles -> conflicts=255 with no wrap.
REQ-042 The bench SHALL cover: rst pulsed low during RDWAIT -> all outputs 0 immediately, no rvalid after release, and the next tie won by req0.
